ram_dual_sync: RTL and testbench
================================

Name: ram_dual_sync

Overview:
Single-clock simple dual-port RAM: one write port and one read port, usable in the same cycle. It is the parametrised successor to the team's two-clock 8x8 dual-port RAM. New behaviour over that block:
- byte-lane write enables
- write-first read/write collision bypass
- registered read with a valid strobe
- a hardware init sweep after reset or on request, replacing the single-cycle array reset
It sits between datapath producers and consumers as scratch or buffer storage.

Parameters:
WIDTH, 16, data word width in bits; must be a multiple of LANE
LANE, 8, bits per write-enable lane; LANES = WIDTH/LANE
DEPTH, 8, number of words; need not be a power of two
NUMBER, 3, address width; must satisfy 2^NUMBER >= DEPTH
INIT_VAL, 0, WIDTH-bit value written to every word by the init sweep

Ports:
clk  in  1  system clock; all logic on the rising edge
reset_n  in  1  synchronous, active-low reset
cs_n  in  1  chip select, active low; high disables both ports
we_n  in  1  write enable, active low
be_n  in  LANES  lane write enables, active low; bit k covers data_in[k*LANE +: LANE]
addr_w  in  NUMBER  write address
data_in  in  WIDTH  write data
re_n  in  1  read enable, active low
addr_r  in  NUMBER  read address
clr_n  in  1  active-low single-cycle request to re-run the init sweep
data_out  out  WIDTH  registered read data
rd_valid  out  1  high for exactly one cycle when data_out carries a new read result
init_busy  out  1  high while the init sweep is running

Behaviour:
- Reset: reset_n low at a clk edge sets data_out=0, rd_valid=0, init_busy=1, state=INIT, sweep counter=0. Array contents are not reset directly.
- FSM states: INIT and RUN.
  - INIT: each cycle writes INIT_VAL to mem[cnt], then cnt+1. After writing address DEPTH-1, go to RUN and set init_busy=0 in that same edge.
  - Sweep length is exactly DEPTH cycles after the reset_n rising edge.
  - RUN -> INIT when clr_n=0 at a clk edge: cnt=0, init_busy=1 from the next cycle.
  - clr_n while already in INIT is ignored; the sweep continues.
  - reset_n low in the middle of a sweep restarts it from address 0.
- In INIT, all user writes and reads are ignored, rd_valid=0 and data_out=0.
- Write (RUN): cs_n=0 and we_n=0 at an edge updates only lanes with be_n[k]=0. If be_n is all ones, nothing is written. If addr_w >= DEPTH, the write is dropped with no aliasing.
- Read (RUN): cs_n=0 and re_n=0 at edge N gives data_out = mem[addr_r] and rd_valid=1 after edge N. Latency is 1 cycle.
  - If addr_r >= DEPTH, data_out=0 and rd_valid=1.
- Read/write collision on the same address in the same cycle is write-first:
  - enabled lanes return the new data_in value
  - disabled lanes return the old memory value
- Read and write to different addresses in the same cycle are fully independent.
- cs_n=1 at an edge: data_out=0 and rd_valid=0 next cycle; no write occurs.
- cs_n=0 with re_n=1: data_out holds its previous value and rd_valid=0.
- A read issued in the cycle the FSM moves INIT->RUN is ignored. The first accepted access is in the first cycle where init_busy=0 is visible.
- No combinational path from any input to any output.

Decomposition:
- Package ram_pkg holds:
  - state encoding (ST_INIT, ST_RUN)
  - LANES derivation function
  - elaboration-time parameter checks (WIDTH % LANE == 0, 2^NUMBER >= DEPTH)
- One sub-module, ram_init_ctrl: INIT/RUN FSM and sweep counter. Outputs init_busy, sweep write enable and sweep address.
- The top level muxes sweep and user write ports and instantiates the array and read register.

Test Plan:
All scenarios use WIDTH=16, LANE=8, DEPTH=8, NUMBER=3, INIT_VAL=16'hA5A5.
1. Reset release -> init_busy=1 for exactly 8 cycles, then 0. Reading addresses 0..7 returns 16'hA5A5 each, with rd_valid=1 one cycle after each request.
2. Write 16'h1234 to addr 3 with be_n=2'b10, then read addr 3 -> data_out=16'hA534 (only the low lane written).
3. Same cycle: write 16'hBEEF (be_n=2'b00) and read, both addr 5 -> next cycle data_out=16'hBEEF, rd_valid=1. Same case with be_n=2'b01 -> data_out=16'hBEA5.
4. Read addr 2 with data_out=16'hA5A5, then cs_n=1 for 1 cycle -> data_out=0, rd_valid=0. Then cs_n=0, re_n=1 -> data_out stays 0.
5. Write 16'h7777 to addr 6, pulse clr_n, pulse clr_n again mid-sweep, wait -> init_busy high exactly 8 cycles. The addr 6 read returns 16'hA5A5.
6. Assert reset_n low at sweep cycle 4 -> sweep restarts; init_busy drops exactly 8 cycles after reset_n returns high. Writes issued during INIT leave memory at 16'hA5A5.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for ram_dual_sync.
//   state_e   - init controller states (ST_INIT sweeps INIT_VAL, ST_RUN serves user accesses)
//   lanes_of  - number of byte-lane write enables for a given word/lane width
//   cfg_ok    - parameter consistency check used at elaboration by the top level
package ram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int unsigned lanes_of(input int unsigned width, input int unsigned lane);
        return width / lane;
    endfunction

    // Word width must split evenly into lanes and the address bus must reach every word.
    function automatic bit cfg_ok(input int unsigned width, input int unsigned lane,
                                  input int unsigned depth, input int unsigned number);
        if (lane == 0 || width == 0 || depth == 0) return 1'b0;
        if ((width % lane) != 0) return 1'b0;
        if (number >= 32) return 1'b1;
        return ((64'd1 << number) >= 64'(depth));
    endfunction

endpackage

// File: rtl/ram_init_ctrl.sv
// ram_init_ctrl: INIT/RUN controller for ram_dual_sync.
// After reset (or a clear request while running) it walks addresses 0..DEPTH-1,
// one per cycle, asking the top level to write INIT_VAL there.
// Ports:
//   clk_i         - clock, rising edge
//   reset_n_i     - synchronous active-low reset, restarts the sweep at address 0
//   clr_n_i       - active-low request to re-run the sweep; ignored while sweeping
//   init_busy_o   - registered, high while the sweep owns the array
//   sweep_we_o    - sweep write strobe for the current cycle
//   sweep_addr_o  - address written by the sweep this cycle
module ram_init_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned NUMBER = 3
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              clr_n_i,
    output logic              init_busy_o,
    output logic              sweep_we_o,
    output logic [NUMBER-1:0] sweep_addr_o
);

    localparam logic [NUMBER-1:0] LAST_ADDR = NUMBER'(DEPTH - 1);

    state_e            state_q;
    logic [NUMBER-1:0] cnt_q;
    logic              busy_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    // Busy drops on the same edge that writes the last word, so the
                    // first cycle showing busy low is already a usable RUN cycle.
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!clr_n_i) begin
                        state_q <= ST_INIT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign init_busy_o  = busy_q;
    assign sweep_we_o   = (state_q == ST_INIT);
    assign sweep_addr_o = cnt_q;

endmodule

// File: rtl/ram_dual_sync.sv
// ram_dual_sync: single-clock simple dual-port RAM (one write port, one read port).
// Byte-lane writes, write-first collision bypass, registered read with valid strobe,
// and a hardware init sweep after reset or on clear request.
// Ports:
//   clk        - clock, rising edge
//   reset_n    - synchronous active-low reset
//   cs_n       - chip select, active low; high idles both ports and zeroes data_out
//   we_n       - write enable, active low
//   be_n       - per-lane write enables, active low
//   addr_w     - write address
//   data_in    - write data
//   re_n       - read enable, active low
//   addr_r     - read address
//   clr_n      - active-low request to re-run the init sweep
//   data_out   - registered read data
//   rd_valid   - one-cycle strobe marking a new read result
//   init_busy  - high while the init sweep runs
module ram_dual_sync
    import ram_pkg::*;
#(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      LANE     = 8,
    parameter int unsigned      DEPTH    = 8,
    parameter int unsigned      NUMBER   = 3,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cs_n,
    input  logic                  we_n,
    input  logic [WIDTH/LANE-1:0] be_n,
    input  logic [NUMBER-1:0]     addr_w,
    input  logic [WIDTH-1:0]      data_in,
    input  logic                  re_n,
    input  logic [NUMBER-1:0]     addr_r,
    input  logic                  clr_n,
    output logic [WIDTH-1:0]      data_out,
    output logic                  rd_valid,
    output logic                  init_busy
);

    localparam int unsigned       LANES   = lanes_of(WIDTH, LANE);
    localparam logic [NUMBER:0]   DEPTH_W = (NUMBER + 1)'(DEPTH);

    if (!cfg_ok(WIDTH, LANE, DEPTH, NUMBER)) begin : g_cfg_err
        $error("ram_dual_sync: WIDTH must be a multiple of LANE and 2**NUMBER >= DEPTH");
    end

    logic              busy_w;
    logic              sweep_we_w;
    logic [NUMBER-1:0] sweep_addr_w;

    ram_init_ctrl #(
        .DEPTH  (DEPTH),
        .NUMBER (NUMBER)
    ) u_init_ctrl (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .clr_n_i      (clr_n),
        .init_busy_o  (busy_w),
        .sweep_we_o   (sweep_we_w),
        .sweep_addr_o (sweep_addr_w)
    );

    // User accesses are only honoured once busy low is visible, which also
    // drops any access presented on the INIT->RUN edge.
    logic acc_en;
    logic wr_in_range;
    logic rd_in_range;
    logic wr_en;
    logic rd_en;

    assign acc_en      = ~busy_w & ~cs_n;
    assign wr_in_range = ({1'b0, addr_w} < DEPTH_W);
    assign rd_in_range = ({1'b0, addr_r} < DEPTH_W);
    assign wr_en       = acc_en & ~we_n & wr_in_range;
    assign rd_en       = acc_en & ~re_n;

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage has no reset; the sweep is the only initialisation path.
    always_ff @(posedge clk) begin
        if (reset_n && sweep_we_w) begin
            mem_q[sweep_addr_w] <= INIT_VAL;
        end else if (wr_en) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (!be_n[k]) begin
                    mem_q[addr_w][k*LANE +: LANE] <= data_in[k*LANE +: LANE];
                end
            end
        end
    end

    // Write-first: lanes being written this cycle at the read address are
    // forwarded from data_in, the rest come from the array.
    logic [WIDTH-1:0] rd_word;

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem_q[addr_r];
            if (wr_en && (addr_w == addr_r)) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    if (!be_n[k]) begin
                        rd_word[k*LANE +: LANE] = data_in[k*LANE +: LANE];
                    end
                end
            end
        end
    end

    logic [WIDTH-1:0] data_out_d, data_out_q;
    logic             rd_valid_d, rd_valid_q;

    always_comb begin
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        if (busy_w || cs_n) begin
            data_out_d = '0;
        end else if (rd_en) begin
            data_out_d = rd_word;
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign data_out  = data_out_q;
    assign rd_valid  = rd_valid_q;
    assign init_busy = busy_w;

endmodule

// File: tb/tb_ram_dual_sync.sv
`timescale 1ns/1ps
module tb_ram_dual_sync;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned LANE   = 8;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned NUMBER = 3;
    localparam logic [15:0] IVAL   = 16'hA5A5;

    logic        clk = 1'b0;
    logic        reset_n, cs_n, we_n, re_n, clr_n;
    logic [1:0]  be_n;
    logic [2:0]  addr_w, addr_r;
    logic [15:0] data_in, data_out;
    logic        rd_valid, init_busy;

    always #5 clk = ~clk;

    ram_dual_sync #(
        .WIDTH    (WIDTH),
        .LANE     (LANE),
        .DEPTH    (DEPTH),
        .NUMBER   (NUMBER),
        .INIT_VAL (IVAL)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cs_n      (cs_n),
        .we_n      (we_n),
        .be_n      (be_n),
        .addr_w    (addr_w),
        .data_in   (data_in),
        .re_n      (re_n),
        .addr_r    (addr_r),
        .clr_n     (clr_n),
        .data_out  (data_out),
        .rd_valid  (rd_valid),
        .init_busy (init_busy)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] mdl [DEPTH];
    logic [15:0] exp_q [$];
    logic [15:0] exp_v;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs_n = 1'b0; we_n = 1'b1; re_n = 1'b1; be_n = 2'b11; clr_n = 1'b1;
        addr_w = '0; addr_r = '0; data_in = '0;
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                          input logic [1:0] ben);
        logic [15:0] r;
        r = old_w;
        for (int k = 0; k < 2; k++) if (!ben[k]) r[k*8 +: 8] = new_w[k*8 +: 8];
        return r;
    endfunction

    // Drives a write and applies it to the model.
    task automatic drive_write(input logic [2:0] a, input logic [15:0] d, input logic [1:0] ben);
        we_n = 1'b0; addr_w = a; data_in = d; be_n = ben;
        mdl[a] = merge(mdl[a], d, ben);
    endtask

    // Drives a read and queues the expected result (model already holds any same-cycle write).
    task automatic drive_read(input logic [2:0] a);
        re_n = 1'b0; addr_r = a;
        exp_q.push_back(mdl[a]);
    endtask

    task automatic test_reset();
        int busy_len;
        reset_n = 1'b0; idle();
        repeat (2) tick();
        n_cmp++; if (data_out !== 16'h0) begin n_bad++; $display("FAIL reset_data_out: got %h want 0000", data_out); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_cmp++; if (init_busy !== 1'b1) begin n_bad++; $display("FAIL reset_init_busy: got %b want 1", init_busy); end
        reset_n = 1'b1;
        busy_len = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            busy_len++;
            if (init_busy === 1'b0) break;
        end
        n_cmp++; if (busy_len != 8) begin n_bad++; $display("FAIL init_len: got %0d cycles want 8", busy_len); end
        for (int a = 0; a < 8; a++) mdl[a] = IVAL;
        for (int a = 0; a < 8; a++) begin
            idle(); drive_read(3'(a));
            tick();
            exp_v = exp_q.pop_front();
            n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL init_rd_valid[%0d]: got %b want 1", a, rd_valid); end
            n_cmp++; if (data_out !== exp_v) begin n_bad++; $display("FAIL init_data[%0d]: got %h want %h", a, data_out, exp_v); end
        end
        idle();
        tick();
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL idle_rd_valid: got %b want 0", rd_valid); end
        n_cmp++; if (data_out !== 16'hA5A5) begin n_bad++; $display("FAIL idle_hold: got %h want a5a5", data_out); end
    endtask

    task automatic test_lane_write();
        idle(); drive_write(3'd3, 16'h1234, 2'b10);
        tick();
        idle(); drive_read(3'd3);
        tick();
        exp_v = exp_q.pop_front();
        n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL lane_rd_valid: got %b want 1", rd_valid); end
        n_cmp++; if (data_out !== exp_v) begin n_bad++; $display("FAIL lane_data: got %h want %h", data_out, exp_v); end
    endtask

    task automatic test_collision();
        logic [2:0]  ca [3];
        logic [1:0]  cb [3];
        ca = '{3'd5, 3'd4, 3'd1};
        cb = '{2'b00, 2'b01, 2'b00};
        // Same-address write+read (full and high-lane-only), then write addr 1 with read addr 0.
        for (int i = 0; i < 3; i++) begin
            idle();
            drive_write(ca[i], (i == 2) ? 16'h1111 : 16'hBEEF, cb[i]);
            drive_read((i == 2) ? 3'd0 : ca[i]);
            tick();
            exp_v = exp_q.pop_front();
            n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL coll_rd_valid[%0d]: got %b want 1", i, rd_valid); end
            n_cmp++; if (data_out !== exp_v) begin n_bad++; $display("FAIL coll_data[%0d]: got %h want %h", i, data_out, exp_v); end
        end
        idle(); drive_read(3'd1);
        tick();
        exp_v = exp_q.pop_front();
        n_cmp++; if (data_out !== exp_v) begin n_bad++; $display("FAIL indep_data: got %h want %h", data_out, exp_v); end
    endtask

    task automatic test_cs_disable();
        idle(); drive_read(3'd2);
        tick();
        exp_v = exp_q.pop_front();
        n_cmp++; if (data_out !== exp_v) begin n_bad++; $display("FAIL cs_pre_data: got %h want %h", data_out, exp_v); end
        // Deselected write must not land in the array.
        idle(); cs_n = 1'b1; we_n = 1'b0; be_n = 2'b00; addr_w = 3'd2; data_in = 16'h0000;
        re_n = 1'b0; addr_r = 3'd2;
        tick();
        n_cmp++; if (data_out !== 16'h0) begin n_bad++; $display("FAIL cs_off_data: got %h want 0000", data_out); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL cs_off_valid: got %b want 0", rd_valid); end
        idle();
        tick();
        n_cmp++; if (data_out !== 16'h0) begin n_bad++; $display("FAIL cs_hold_data: got %h want 0000", data_out); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL cs_hold_valid: got %b want 0", rd_valid); end
        idle(); drive_read(3'd2);
        tick();
        exp_v = exp_q.pop_front();
        n_cmp++; if (data_out !== exp_v) begin n_bad++; $display("FAIL cs_no_write: got %h want %h", data_out, exp_v); end
    endtask

    task automatic test_clear();
        int busy_len, bad_init;
        idle(); drive_write(3'd6, 16'h7777, 2'b00);
        tick();
        idle(); drive_read(3'd6);
        tick();
        exp_v = exp_q.pop_front();
        n_cmp++; if (data_out !== exp_v) begin n_bad++; $display("FAIL clr_pre_data: got %h want %h", data_out, exp_v); end
        idle(); clr_n = 1'b0;
        tick();
        n_cmp++; if (init_busy !== 1'b1) begin n_bad++; $display("FAIL clr_busy: got %b want 1", init_busy); end
        busy_len = 1; bad_init = 0;
        for (int i = 0; i < 20; i++) begin
            idle(); re_n = 1'b0; addr_r = 3'd6;
            clr_n = (i == 3) ? 1'b0 : 1'b1;
            tick();
            if (init_busy === 1'b0) break;
            busy_len++;
            if (rd_valid !== 1'b0 || data_out !== 16'h0) bad_init++;
        end
        n_cmp++; if (busy_len != 8) begin n_bad++; $display("FAIL clr_len: got %0d cycles want 8", busy_len); end
        n_cmp++; if (bad_init != 0) begin n_bad++; $display("FAIL clr_init_outputs: got %0d bad cycles want 0", bad_init); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL clr_edge_read: got rd_valid %b want 0", rd_valid); end
        for (int a = 0; a < 8; a++) mdl[a] = IVAL;
        for (int a = 3; a < 7; a += 3) begin
            idle(); drive_read(3'(a));
            tick();
            exp_v = exp_q.pop_front();
            n_cmp++; if (data_out !== exp_v) begin n_bad++; $display("FAIL clr_data[%0d]: got %h want %h", a, data_out, exp_v); end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int busy_len;
        idle(); drive_write(3'd0, 16'h0F0F, 2'b00);
        tick();
        idle(); clr_n = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            idle(); we_n = 1'b0; be_n = 2'b00; addr_w = 3'(i + 2); data_in = 16'hDEAD;
            tick();
        end
        reset_n = 1'b0; idle();
        tick();
        reset_n = 1'b1;
        n_cmp++; if (init_busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 1", init_busy); end
        busy_len = 0;
        for (int i = 0; i < 20; i++) begin
            idle(); we_n = 1'b0; be_n = 2'b00; addr_w = 3'(i % 8); data_in = 16'h5A5A ^ 16'(i);
            tick();
            busy_len++;
            if (init_busy === 1'b0) break;
        end
        n_cmp++; if (busy_len != 8) begin n_bad++; $display("FAIL rst_mid_len: got %0d cycles want 8", busy_len); end
        for (int a = 0; a < 8; a++) mdl[a] = IVAL;
        for (int a = 0; a < 8; a++) begin
            idle(); drive_read(3'(a));
            tick();
            exp_v = exp_q.pop_front();
            n_cmp++; if (data_out !== exp_v) begin n_bad++; $display("FAIL rst_mid_data[%0d]: got %h want %h", a, data_out, exp_v); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        idle();
        test_reset();
        test_lane_write();
        test_collision();
        test_cs_disable();
        test_clear();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
